mem_write_buffer: RTL

Posted-store write buffer in the MEM stage, between the EX/MEM pipeline register and the SRAM controller. Stores are accepted in one cycle and drained to SRAM in the background, so the pipeline freezes only when the buffer is full or a load needs SRAM. Loads that miss the buffer drain it first, then issue an SRAM read and return the addressed 32-bit word from the 64-bit SRAM response. `ready` drives the pipeline freeze: the pipeline freezes when `ready` is low.

---
 rtl/mem_write_buffer_if.sv | 30 +++
 rtl/mem_write_buffer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mem_write_buffer_if.sv
// Bus bundle between the EX/MEM pipeline, the posted-store write buffer and the SRAM controller.
// The slave modport is the buffer's view; the master modport is the view of its surroundings.
interface mem_write_buffer_if;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        ready;
    logic [31:0] read_data;
    logic        full;
    logic        empty;
    logic        SRAM_ready;
    logic [63:0] SRAM_read_data;
    logic        SRAM_write_en;
    logic        SRAM_read_en;
    logic [31:0] SRAM_address;
    logic [31:0] SRAM_write_data;

    modport slave (
        input  MEM_R_EN, MEM_W_EN, address, write_data, SRAM_ready, SRAM_read_data,
        output ready, read_data, full, empty,
        output SRAM_write_en, SRAM_read_en, SRAM_address, SRAM_write_data
    );

    modport master (
        output MEM_R_EN, MEM_W_EN, address, write_data, SRAM_ready, SRAM_read_data,
        input  ready, read_data, full, empty,
        input  SRAM_write_en, SRAM_read_en, SRAM_address, SRAM_write_data
    );
endinterface

// File: rtl/mem_write_buffer.sv
// Posted-store write buffer: stores enter a circular FIFO and drain to SRAM in the background.
// Define WB_LOAD_FWD_EN to build the load-forwarding comparators; otherwise every load drains the buffer first.
module mem_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_write_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    logic [29:0]      addr_mem_r [DEPTH];
    logic [31:0]      data_mem_r [DEPTH];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;
    state_t           state_r;
    logic             sram_we_r;
    logic             sram_re_r;
    logic [31:0]      sram_addr_r;
    logic [31:0]      sram_wdata_r;

    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;
    logic             hit_s;
    logic [31:0]      fwd_data_s;
    logic             read_done_s;
    logic [31:0]      sram_word_s;
    logic             ready_s;
    logic [31:0]      read_data_s;

    assign full_s      = (count_r == CNT_W'(DEPTH));
    assign empty_s     = (count_r == {CNT_W{1'b0}});
    assign push_s      = bus.MEM_W_EN & ~full_s;
    assign pop_s       = (state_r == WRITE) & bus.SRAM_ready;
    assign read_done_s = (state_r == READ) & bus.SRAM_ready;
    assign sram_word_s = bus.address[2] ? bus.SRAM_read_data[63:32] : bus.SRAM_read_data[31:0];

`ifdef WB_LOAD_FWD_EN
    // Forwarding search: walk oldest to youngest so the youngest matching entry wins
    always_comb begin
        logic [PTR_W-1:0] idx_v;
        logic             match_v;
        hit_s      = 1'b0;
        fwd_data_s = 32'd0;
        idx_v      = {PTR_W{1'b0}};
        match_v    = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            idx_v      = head_r + PTR_W'(k);
            match_v    = (CNT_W'(k) < count_r) && (addr_mem_r[idx_v] == bus.address[31:2]);
            hit_s      = hit_s | match_v;
            fwd_data_s = match_v ? data_mem_r[idx_v] : fwd_data_s;
        end
    end
`else
    assign hit_s      = 1'b0;
    assign fwd_data_s = 32'd0;
`endif

    // Pipeline handshake: stores wait on full, loads complete on a hit or the SRAM response
    always_comb begin
        ready_s     = 1'b1;
        read_data_s = 32'd0;
        if (bus.MEM_W_EN) begin
            ready_s = ~full_s;
        end else if (bus.MEM_R_EN) begin
            if (hit_s) begin
                read_data_s = fwd_data_s;
            end else if (read_done_s) begin
                read_data_s = sram_word_s;
            end else begin
                ready_s = 1'b0;
            end
        end else begin
            ready_s = 1'b1;
        end
    end

    // FIFO storage, pointers and occupancy count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem_r[i] <= 30'd0;
                data_mem_r[i] <= 32'd0;
            end
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                addr_mem_r[tail_r] <= bus.address[31:2];
                data_mem_r[tail_r] <= bus.write_data;
                tail_r             <= tail_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                head_r <= head_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    // SRAM sequencer; draining always takes priority over a pending load miss
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            sram_we_r    <= 1'b0;
            sram_re_r    <= 1'b0;
            sram_addr_r  <= 32'd0;
            sram_wdata_r <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!empty_s) begin
                        sram_addr_r  <= {addr_mem_r[head_r], 2'b00};
                        sram_wdata_r <= data_mem_r[head_r];
                        sram_we_r    <= 1'b1;
                        state_r      <= WRITE;
                    end else if (bus.MEM_R_EN && !hit_s) begin
                        sram_addr_r <= bus.address;
                        sram_re_r   <= 1'b1;
                        state_r     <= READ;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WRITE: begin
                    if (bus.SRAM_ready) begin
                        sram_we_r <= 1'b0;
                        state_r   <= IDLE;
                    end else begin
                        state_r <= WRITE;
                    end
                end
                READ: begin
                    if (bus.SRAM_ready) begin
                        sram_re_r <= 1'b0;
                        state_r   <= IDLE;
                    end else begin
                        state_r <= READ;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    sram_we_r <= 1'b0;
                    sram_re_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready           = ready_s;
    assign bus.read_data       = read_data_s;
    assign bus.full            = full_s;
    assign bus.empty           = empty_s;
    assign bus.SRAM_write_en   = sram_we_r;
    assign bus.SRAM_read_en    = sram_re_r;
    assign bus.SRAM_address    = sram_addr_r;
    assign bus.SRAM_write_data = sram_wdata_r;
endmodule
